// File: rtl/pcs_pkg.sv
// Shared PCS constants: block framing widths and receive-gearbox buffer sizing.
package pcs_pkg;

  localparam int unsigned HEAD_W   = 2;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned BLOCK_W  = HEAD_W + DATA_W;
  localparam int unsigned SERDES_W = 32;
  localparam int unsigned GB_BUF_W = BLOCK_W + SERDES_W - 1;
  localparam int unsigned GB_CNT_W = 7;

endpackage

// File: rtl/pcs_gearbox_rx.sv
// Receive gearbox: repacks a 32-bit SERDES word stream into 66-bit blocks (header + payload)
// and applies single-bit slips requested by block sync.
module pcs_gearbox_rx #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned HEAD_W = 2,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              serdes_v_i,
  input  logic [IN_W-1:0]   serdes_data_i,
  input  logic              slip_v_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
);
  import pcs_pkg::*;

  localparam int unsigned BlkW = HEAD_W + DATA_W;
  localparam int unsigned BufW = BlkW + IN_W - 1;
  localparam int unsigned CntW = GB_CNT_W;

  logic [BufW-1:0]   buf_q, buf_d, comb;
  logic [CntW-1:0]   cnt_q, cnt_d, ccnt;
  logic              slip_pend_q, slip_pend_d;
  logic              valid_q, valid_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    slip_pend_d = slip_pend_q;
    valid_d     = 1'b0;
    head_d      = head_q;
    data_d      = data_q;
    comb        = buf_q | (BufW'(serdes_data_i) << cnt_q);
    ccnt        = cnt_q + CntW'(IN_W);

    if (serdes_v_i) begin
      slip_pend_d = 1'b0;
      // Dropping the oldest bit of the combined stream shifts block framing by one.
      if (slip_v_i || slip_pend_q) begin
        comb = comb >> 1;
        ccnt = ccnt - CntW'(1);
      end
      if (ccnt >= CntW'(BlkW)) begin
        valid_d = 1'b1;
        head_d  = comb[HEAD_W-1:0];
        data_d  = comb[BlkW-1:HEAD_W];
        buf_d   = comb >> BlkW;
        cnt_d   = ccnt - CntW'(BlkW);
      end else begin
        buf_d = comb;
        cnt_d = ccnt;
      end
    end else if (slip_v_i) begin
      slip_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      slip_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      head_q      <= '0;
      data_q      <= '0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      slip_pend_q <= slip_pend_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      data_q      <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_pcs_gearbox_rx.sv
// Directed bench for pcs_gearbox_rx with a bit-queue reference for the repacked stream.
module tb_pcs_gearbox_rx;

  logic        clk = 1'b0;
  logic        nreset;
  logic        serdes_v_i;
  logic [31:0] serdes_data_i;
  logic        slip_v_i;
  logic        valid_o;
  logic [1:0]  head_o;
  logic [63:0] data_o;

  int checks = 0;
  int fails  = 0;

  // Reference: raw bit FIFO, oldest bit at the front.
  bit          mq[$];
  bit          m_pend;
  logic        m_valid;
  logic [1:0]  m_head;
  logic [63:0] m_data;
  logic [30:0] prbs_st;

  pcs_gearbox_rx #(
    .IN_W  (32),
    .HEAD_W(2),
    .DATA_W(64)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .serdes_v_i   (serdes_v_i),
    .serdes_data_i(serdes_data_i),
    .slip_v_i     (slip_v_i),
    .valid_o      (valid_o),
    .head_o       (head_o),
    .data_o       (data_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_pend  = 1'b0;
    m_valid = 1'b0;
    m_head  = '0;
    m_data  = '0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [31:0] d);
    logic [65:0] blk;
    bit          b;
    m_valid = 1'b0;
    if (v) begin
      for (int i = 0; i < 32; i++) mq.push_back(d[i]);
      if (s || m_pend) b = mq.pop_front();
      m_pend = 1'b0;
      if (mq.size() >= 66) begin
        for (int i = 0; i < 66; i++) blk[i] = mq.pop_front();
        m_head  = blk[1:0];
        m_data  = blk[65:2];
        m_valid = 1'b1;
      end
    end else if (s) begin
      m_pend = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance the reference, sample #1 after the edge.
  task automatic cyc(input logic v, input logic s, input logic [31:0] d);
    serdes_v_i    = v;
    slip_v_i      = s;
    serdes_data_i = d;
    model_step(v, s, d);
    @(posedge clk);
    #1;
    serdes_v_i = 1'b0;
    slip_v_i   = 1'b0;
  endtask

  task automatic apply_reset();
    serdes_v_i = 1'b0;
    slip_v_i   = 1'b0;
    nreset     = 1'b0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    model_reset();
  endtask

  // PRBS31 (x^31 + x^28 + 1), first generated bit lands in bit 0.
  task automatic next_prbs(output logic [31:0] w);
    logic nb;
    for (int i = 0; i < 32; i++) begin
      nb      = prbs_st[30] ^ prbs_st[27];
      prbs_st = {prbs_st[29:0], nb};
      w[i]    = nb;
    end
  endtask

  task automatic test_reset();
    serdes_v_i    = 1'b0;
    slip_v_i      = 1'b0;
    serdes_data_i = '0;
    nreset        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0 || head_o !== 2'b00 || data_o !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b head=%b data=%h, required 0/00/0",
               valid_o, head_o, data_o);
    end
    checks++;
    if (dut.cnt_q !== 7'd0) begin
      fails++;
      $display("FAIL reset_cnt: got %0d, required 0", dut.cnt_q);
    end
    nreset = 1'b1;
    model_reset();
  endtask

  task automatic test_first_blocks();
    logic [31:0] w0, w1, w2;
    logic [65:0] exp;
    w0  = 32'hDEADBEEF;
    w1  = 32'h01234567;
    w2  = 32'hCAFEF00D;
    exp = {w2[1:0], w1, w0};
    apply_reset();
    cyc(1'b1, 1'b0, w0);
    checks++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL first_w0_valid: got %b, required 0", valid_o);
    end
    cyc(1'b1, 1'b0, w1);
    checks++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL first_w1_valid: got %b, required 0", valid_o);
    end
    cyc(1'b1, 1'b0, w2);
    checks++;
    if (valid_o !== 1'b1 || {data_o, head_o} !== exp) begin
      fails++;
      $display("FAIL first_block: valid=%b blk=%h, required 1/%h", valid_o, {data_o, head_o}, exp);
    end
    checks++;
    if (dut.cnt_q !== 7'd30) begin
      fails++;
      $display("FAIL first_cnt: got %0d, required 30", dut.cnt_q);
    end
  endtask

  task automatic test_cadence();
    logic [31:0] w;
    int          c, pulses;
    logic        ev;
    apply_reset();
    prbs_st = 31'h7FFF_FFFF;
    c       = 0;
    pulses  = 0;
    for (int k = 0; k < 33; k++) begin
      next_prbs(w);
      cyc(1'b1, 1'b0, w);
      c  = c + 32;
      ev = (c >= 66);
      if (ev) c = c - 66;
      checks++;
      if (valid_o !== ev) begin
        fails++;
        $display("FAIL cadence_valid[%0d]: got %b, required %b", k, valid_o, ev);
      end
      if (valid_o === 1'b1) begin
        pulses++;
        checks++;
        if (head_o !== m_head || data_o !== m_data) begin
          fails++;
          $display("FAIL cadence_block[%0d]: got %b/%h, required %b/%h",
                   k, head_o, data_o, m_head, m_data);
        end
      end
    end
    checks++;
    if (pulses != 16) begin
      fails++;
      $display("FAIL cadence_pulses: got %0d, required 16", pulses);
    end
    checks++;
    if (dut.cnt_q !== 7'd0) begin
      fails++;
      $display("FAIL cadence_cnt: got %0d, required 0", dut.cnt_q);
    end
  endtask

  task automatic test_single_slip();
    logic [63:0] pl[8];
    bit          tx[$];
    logic [31:0] w;
    int          nb;
    apply_reset();
    tx.push_back(1'b1);
    for (int k = 0; k < 8; k++) begin
      pl[k] = {$urandom(), $urandom()};
      tx.push_back(1'b1);
      tx.push_back(1'b0);
      for (int i = 0; i < 64; i++) tx.push_back(pl[k][i]);
    end
    nb = 0;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 32; i++) w[i] = tx.pop_front();
      cyc(1'b1, (k == 0), w);
      if (valid_o === 1'b1) begin
        checks++;
        if (head_o !== 2'b01 || data_o !== pl[nb]) begin
          fails++;
          $display("FAIL slip_block[%0d]: got %b/%h, required 01/%h", nb, head_o, data_o, pl[nb]);
        end
        nb++;
      end
    end
    checks++;
    if (nb != 7) begin
      fails++;
      $display("FAIL slip_block_count: got %0d, required 7", nb);
    end
  endtask

  task automatic test_slip_idle_merge();
    logic [31:0] w;
    apply_reset();
    prbs_st = 31'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      next_prbs(w);
      cyc(1'b1, 1'b0, w);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, (k < 2), $urandom());
      checks++;
      if (valid_o !== 1'b0 || head_o !== m_head || data_o !== m_data) begin
        fails++;
        $display("FAIL merge_idle_hold[%0d]: got %b/%b/%h, required 0/%b/%h",
                 k, valid_o, head_o, data_o, m_head, m_data);
      end
    end
    for (int k = 0; k < 8; k++) begin
      next_prbs(w);
      cyc(1'b1, 1'b0, w);
      checks++;
      if (valid_o !== m_valid || head_o !== m_head || data_o !== m_data) begin
        fails++;
        $display("FAIL merge_resume[%0d]: got %b/%b/%h, required %b/%b/%h",
                 k, valid_o, head_o, data_o, m_valid, m_head, m_data);
      end
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w;
    int          pulses;
    int          gaps;
    apply_reset();
    prbs_st = 31'h0ACE_1234;
    pulses  = 0;
    for (int k = 0; k < 24; k++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        cyc(1'b0, 1'b0, $urandom());
        checks++;
        if (valid_o !== 1'b0 || head_o !== m_head || data_o !== m_data) begin
          fails++;
          $display("FAIL gap_hold[%0d]: got %b/%b/%h, required 0/%b/%h",
                   k, valid_o, head_o, data_o, m_head, m_data);
        end
      end
      next_prbs(w);
      cyc(1'b1, 1'b0, w);
      if (valid_o === 1'b1) pulses++;
      checks++;
      if (valid_o !== m_valid || head_o !== m_head || data_o !== m_data) begin
        fails++;
        $display("FAIL gap_word[%0d]: got %b/%b/%h, required %b/%b/%h",
                 k, valid_o, head_o, data_o, m_valid, m_head, m_data);
      end
    end
    checks++;
    if (pulses != 11) begin
      fails++;
      $display("FAIL gap_pulses: got %0d, required 11", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0, w1, w2;
    logic [65:0] exp;
    apply_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, $urandom());
    serdes_v_i    = 1'b1;
    slip_v_i      = 1'b1;
    serdes_data_i = 32'hFFFF_FFFF;
    nreset        = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0 || head_o !== 2'b00 || data_o !== 64'd0 || dut.cnt_q !== 7'd0) begin
      fails++;
      $display("FAIL midreset_state: valid=%b head=%b data=%h cnt=%0d, required all 0",
               valid_o, head_o, data_o, dut.cnt_q);
    end
    nreset = 1'b1;
    model_reset();
    w0  = 32'h1357_9BDF;
    w1  = 32'h2468_ACE0;
    w2  = 32'h0000_0002;
    exp = {w2[1:0], w1, w0};
    cyc(1'b1, 1'b0, w0);
    cyc(1'b1, 1'b0, w1);
    checks++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL midreset_early_valid: got %b, required 0", valid_o);
    end
    cyc(1'b1, 1'b0, w2);
    checks++;
    if (valid_o !== 1'b1 || {data_o, head_o} !== exp) begin
      fails++;
      $display("FAIL midreset_block: valid=%b blk=%h, required 1/%h",
               valid_o, {data_o, head_o}, exp);
    end
  endtask

  initial begin
    test_reset();
    test_first_blocks();
    test_cadence();
    test_single_slip();
    test_slip_idle_merge();
    test_gaps();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pcs_gearbox_rx.md
# pcs_gearbox_rx

Per-lane receive gearbox between the SERDES and the block-sync stage. Repacks a continuous 32-bit SERDES word stream into 66-bit blocks, a 2-bit sync header plus a 64-bit payload. It implements the single-bit slip that the block-sync stage requests while it hunts for header alignment. Outputs feed the block-sync stage's header input and the downstream descrambler/decoder.

## Interface
Parameters:
- `IN_W`, default 32: SERDES word width.
- `HEAD_W`, default 2: sync header width.
- `DATA_W`, default 64: block payload width.

Ports:
- `clk`, input, 1: clock.
- `nreset`, input, 1: reset; synchronous, active-low.
- `serdes_v_i`, input, 1: `serdes_data_i` is valid this cycle and is accepted.
- `serdes_data_i`, input, `IN_W`: received bits; bit 0 is the oldest on the wire.
- `slip_v_i`, input, 1: slip request from block sync; discard one bit.
- `valid_o`, output, 1: `head_o`/`data_o` hold a new block this cycle.
- `head_o`, output, `HEAD_W`: sync header; bit 0 is the oldest.
- `data_o`, output, `DATA_W`: block payload; bit 0 is the oldest.

## Operation
- **Buffer.** State is a 97-bit buffer `buf` and a bit count `cnt` (0..65 between accepts, 7 bits wide). There is also a `slip_pend` flag.
- **Accept.** An accept occurs when `serdes_v_i`=1. The combined value is `comb = buf | (serdes_data_i << cnt)` and the combined count is `ccnt = cnt + 32`.
- **Slip on accept.** A slip applies on an accept when `slip_v_i`=1 or `slip_pend`=1. It sets `comb = comb >> 1` and `ccnt = ccnt - 1`.
- **Emit.** If `ccnt >= 66`, a block is emitted: `head = comb[1:0]` and `data = comb[65:2]`. Then `buf <= comb >> 66` and `cnt <= ccnt - 66`. Otherwise `buf <= comb` and `cnt <= ccnt`.
- **Pending slip.** If `slip_v_i`=1 on a cycle with no accept, `slip_pend` is set. It is cleared on the next accept, where the slip is applied.
- **Slip merging.**
  - A second slip while `slip_pend`=1 is dropped; one pending slip at most.
  - A slip coinciding with an accept is consumed by that accept and does not set `slip_pend`.
- **Idle.** With no accept, `buf`, `cnt` and the outputs hold, and `valid_o` is 0.
- **No overflow.** `cnt` stays ≤ 65, so `ccnt` is at most 97 and the 97-bit buffer never overflows.
- **Steady cadence.** With continuous input, 33 accepts yield exactly 16 blocks. Starting from `cnt`=0 the count sequence is 32, 64, 96→30, 62, 94→28, … and returns to 0 after 33 words.
- **Block framing.** The gearbox does no header checking; block framing is set purely by the history of slips.

## Timing
- **Reset.** In the cycle after `nreset`=0 is sampled: `valid_o`=0, `head_o`=0, `data_o`=0, `buf`=0, `cnt`=0, `slip_pend`=0. Reset mid-stream discards all partial bits.
- **Latency.** `valid_o`, `head_o` and `data_o` are registered. A block appears one cycle after the accept that completes it. `valid_o` is a single-cycle pulse per block.
- **Output hold.** `head_o` and `data_o` hold their last block while `valid_o`=0.
- **Throughput.** There is no back-pressure; the consumer must take every `valid_o` pulse.
- **Slip-to-effect latency.**
  - A slip sampled with an accept affects the block emitted from that accept or later.
  - A slip without an accept takes effect at the next accept.
- **Block-sync handshake.** The block-sync stage issues a slip no more than once per received block. Any faster slips merge as described under Operation.

## Structure
- Shared package `pcs_pkg` holds:
  - `HEAD_W`, `DATA_W`, `BLOCK_W` (=66) and `SERDES_W` (=32);
  - the buffer width `GB_BUF_W` (=`BLOCK_W`+`SERDES_W`-1) and `GB_CNT_W` (=7).
- There is a single module with no sub-module. The shift/merge logic is one combinational block and the state is one register block.

## Test plan
- **Reset and first blocks.** After reset, send 3 words W0, W1, W2.
  - Expect `valid_o`=0 for the first two accepts.
  - One cycle after W2: `valid_o`=1 with `{data_o, head_o}` = `{W2[1:0], W1, W0}`.
- **Cadence.** Send 33 consecutive words of a PRBS31 stream. Expect exactly 16 `valid_o` pulses, with `valid_o`=0 on the cycles after accepts 1, 2, 4, … per the count sequence. Expect `cnt`=0 after word 33.
- **Single slip.** Send a stream of 66-bit blocks with header 2'b01, offset by 1 bit. Pulse `slip_v_i` once with an accept. Expect every following block to have `head_o`=2'b01 and a payload matching the transmitted blocks.
- **Slip while idle and slip merging.** Deassert `serdes_v_i` and pulse `slip_v_i` twice. On resume, expect exactly a one-bit shift relative to the unslipped reference model, not two.
- **Input gaps.** Insert random `serdes_v_i`=0 gaps. Expect the output block sequence to be identical to the gap-free run, and outputs held during gaps.
- **Reset mid-operation.** Assert `nreset`=0 with `cnt`≠0. Expect all outputs 0 and the first block after restart equal to `{W2[1:0], W1, W0}` of the new words.
